// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin two-requester arbiter and sequencer for the shared memory port
module mem_port_arbiter #(
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [31:0] rdata,
   output logic        err,
   output logic        sel,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state;
   logic last;
   logic win;
   logic timeout;
   logic [CW-1:0] wait_cnt;
   assign win = req1 & (~req0 | ~last);
   assign timeout = wait_cnt == CW'(MAX_WAIT - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last <= 1'b1;
         sel <= 1'b0;
         wait_cnt <= '0;
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err <= 1'b0;
         rdata <= '0;
         mem_req <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_we <= 1'b0;
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: if (req0 | req1) begin
               mem_addr <= win ? addr1 : addr0;
               mem_wdata <= win ? wdata1 : wdata0;
               mem_we <= win ? we1 : we0;
               sel <= win;
               last <= win;
               wait_cnt <= '0;
               gnt0 <= ~win;
               gnt1 <= win;
               mem_req <= 1'b1;
               state <= BUSY;
            end
            BUSY: if (mem_ready | timeout) begin
               rdata <= (mem_ready & ~mem_we) ? mem_rdata : '0;
               err <= ~mem_ready;
               rvalid0 <= ~sel;
               rvalid1 <= sel;
               mem_req <= 1'b0;
               state <= DONE;
            end else begin
               wait_cnt <= wait_cnt + CW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, random transactions vs. a transaction-level model, corner sequences
module tb_mem_port_arbiter;
   localparam int MW = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_ready = 0;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
   logic gnt0, gnt1, rvalid0, rvalid1, err, sel, mem_req, mem_we;
   logic [31:0] rdata, mem_addr, mem_wdata;
   int n_chk = 0, n_fail = 0;
   logic last_m = 1'b1;
   always #5 clk = ~clk;
   mem_port_arbiter #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .err(err), .sel(sel),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );
   typedef struct {
      logic r0, r1, w0, w1;
      logic [31:0] a0, a1, d0, d1;
      int lat;
      logic [31:0] mrd;
      logic ew;
      logic [31:0] erd;
      logic eerr;
      int ebusy;
   } vec_t;
   vec_t tbl[6];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_quiet(input string name);
      chk({name, "_gnt"}, {gnt0, gnt1}, 0);
      chk({name, "_rvalid"}, {rvalid0, rvalid1}, 0);
      chk({name, "_err"}, err, 0);
      chk({name, "_mem_req"}, mem_req, 0);
   endtask
   // Starts in an IDLE cycle, runs one transaction, ends in the following IDLE cycle.
   task automatic run_txn(input logic r0, r1, w0, w1, input logic [31:0] a0, a1, d0, d1,
                          input int lat, input logic [31:0] mrd, input logic ew,
                          input logic [31:0] erd, input logic eerr, input int ebusy);
      int c;
      logic [31:0] ea, ed;
      ea = ew ? a1 : a0;
      ed = ew ? d1 : d0;
      req0 = r0; req1 = r1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      mem_ready = 1'($urandom_range(0, 1));
      tick();
      chk("gnt", {gnt0, gnt1}, {~ew, ew});
      chk("sel", sel, ew);
      if (ew) begin req1 = 0; addr1 = $urandom; wdata1 = $urandom; we1 = ~we1; end
      else begin req0 = 0; addr0 = $urandom; wdata0 = $urandom; we0 = ~we0; end
      c = 0;
      while (mem_req === 1'b1 && c < 20) begin
         if (c > 0) chk("gnt_once", {gnt0, gnt1}, 0);
         chk("mem_addr", mem_addr, ea);
         chk("mem_wdata", mem_wdata, ed);
         chk("mem_we", mem_we, ew ? w1 : w0);
         chk("busy_rvalid", {rvalid0, rvalid1}, 0);
         mem_ready = (c == lat);
         mem_rdata = (c == lat) ? mrd : $urandom;
         tick();
         c++;
      end
      chk("busy_cycles", c, ebusy);
      chk("rvalid", {rvalid0, rvalid1}, {~ew, ew});
      chk("err", err, eerr);
      chk("rdata", rdata, erd);
      chk("done_gnt", {gnt0, gnt1}, 0);
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      tick();
      chk_quiet("idle");
      chk("rdata_hold", rdata, erd);
      mem_ready = 0;
   endtask
   initial begin
      logic p_req[2];
      logic p_we[2];
      logic [31:0] p_a[2], p_d[2];
      tbl[0] = '{1, 0, 0, 0, 32'h40, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 2};
      tbl[1] = '{0, 1, 0, 1, 0, 32'h100, 0, 32'h12345678, 0, 32'hAAAA5555, 1, 0, 0, 1};
      tbl[2] = '{1, 0, 0, 0, 32'h200, 0, 0, 0, 99, 32'h77777777, 0, 0, 1, MW};
      tbl[3] = '{0, 1, 0, 0, 0, 32'h300, 0, 0, MW - 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, MW};
      tbl[4] = '{1, 1, 0, 0, 32'h400, 32'h404, 0, 0, 0, 32'h11111111, 0, 32'h11111111, 0, 1};
      tbl[5] = '{1, 1, 0, 1, 32'h400, 32'h404, 0, 32'h99, 2, 32'h22222222, 1, 0, 0, 3};
      tick();
      tick();
      chk_quiet("reset");
      chk("reset_sel", sel, 0);
      chk("reset_bus", {mem_addr, mem_wdata, rdata} != 0, 0);
      chk("reset_we", mem_we, 0);
      rst_n = 1;
      foreach (tbl[i]) begin
         run_txn(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, tbl[i].a0, tbl[i].a1, tbl[i].d0,
                 tbl[i].d1, tbl[i].lat, tbl[i].mrd, tbl[i].ew, tbl[i].erd, tbl[i].eerr, tbl[i].ebusy);
         last_m = tbl[i].ew;
      end
      p_req = '{0, 0};
      for (int n = 0; n < 40; n++) begin
         int lat;
         logic w, to;
         logic [31:0] mrd;
         for (int i = 0; i < 2; i++)
            if (!p_req[i] && $urandom_range(0, 1) == 1) begin
               p_req[i] = 1; p_we[i] = 1'($urandom_range(0, 1)); p_a[i] = $urandom; p_d[i] = $urandom;
            end
         if (!p_req[0] && !p_req[1]) begin
            p_req[0] = 1; p_we[0] = 0; p_a[0] = $urandom; p_d[0] = $urandom;
         end
         w = (p_req[0] && p_req[1]) ? ~last_m : p_req[1];
         lat = $urandom_range(0, 5);
         to = lat >= MW;
         mrd = $urandom;
         run_txn(p_req[0], p_req[1], p_we[0], p_we[1], p_a[0], p_a[1], p_d[0], p_d[1], lat, mrd,
                 w, (p_we[w] || to) ? 32'h0 : mrd, to, to ? MW : lat + 1);
         p_req[w] = 0;
         last_m = w;
      end
      req0 = 0; req1 = 0;
      mem_ready = 1;
      mem_rdata = 32'hFFFF0000;
      tick();
      chk_quiet("stray");
      mem_ready = 0;
      tick();
      chk_quiet("stray_after");
      run_txn(0, 1, 0, 0, 0, 32'h500, 0, 0, 2, 32'h0BADF00D, 1, 32'h0BADF00D, 0, 3);
      req0 = 1; we0 = 0; addr0 = 32'h600;
      tick();
      chk("rst_pre_gnt", gnt0, 1);
      req0 = 0;
      tick();
      chk("rst_pre_busy", mem_req, 1);
      rst_n = 0;
      #1;
      chk_quiet("rst_async");
      req0 = 1; req1 = 1; mem_ready = 1;
      tick();
      tick();
      chk_quiet("rst_hold");
      mem_ready = 0;
      rst_n = 1;
      tick();
      chk("rst_first_gnt", {gnt0, gnt1}, 2'b10);
      req0 = 0; req1 = 0; mem_ready = 1; mem_rdata = 32'h13572468;
      tick();
      chk("rst_rvalid", {rvalid0, rvalid1}, 2'b10);
      chk("rst_rdata", rdata, 32'h13572468);
      mem_ready = 0;
      tick();
      rst_n = 0;
      req0 = 1; req1 = 1; addr0 = 32'h1000; addr1 = 32'h2000; we0 = 0; we1 = 0;
      mem_ready = 1; mem_rdata = 32'h5A5A5A5A;
      tick();
      rst_n = 1;
      begin
         logic ew = 0, pw = 0;
         int last_g = 0, ng = 0;
         for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (gnt0 || gnt1) begin
               chk("cont_gnt", gnt1, ew);
               chk("cont_sel", sel, ew);
               chk("cont_addr", mem_addr, ew ? 32'h2000 : 32'h1000);
               if (ng > 0) chk("cont_gap", cyc - last_g, 3);
               last_g = cyc; pw = ew; ew = ~ew; ng++;
            end
            if (rvalid0 || rvalid1) begin
               chk("cont_rvalid", {rvalid0, rvalid1}, {~pw, pw});
               chk("cont_rv_time", cyc - last_g, 1);
               chk("cont_rdata", rdata, 32'h5A5A5A5A);
            end
         end
         chk("cont_count", ng, 4);
      end
      req0 = 0; req1 = 0; mem_ready = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
